rd53_cmd_serializer: RTL and testbench
======================================

# rd53_cmd_serializer

DAQ-side command-stream generator for the RD53A CMD input. Accepts 16-bit command frames over a valid/ready interface, buffers them, and serializes them MSB-first at one bit per `CMD_CLK` (160 Mb/s) onto the line that drives `CMD_P_PAD`/`CMD_N_PAD`. It inserts the sync frame periodically so the chip's CDR and frame aligner stay locked, and fills idle time with NOOP frames. It sits directly upstream of the chip's command decoder.

## Interface
Parameters:
- `SYNC_INTERVAL`, default 32: maximum number of non-sync frames between sync frames (range 2..255).
- `FIFO_DEPTH`, default 8: input frame buffer depth (power of 2, ≥2).

Ports:
- `CMD_CLK`  in  1  160 MHz command clock; the only clock.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `FRAME_DATA`  in  16  command frame, bit 15 is transmitted first.
- `FRAME_LAST`  in  1  marks the final frame of a multi-frame command (single-frame commands assert it).
- `FRAME_VALID`  in  1  frame offered.
- `FRAME_READY`  out  1  FIFO not full; transfer occurs when VALID && READY on a rising edge.
- `CLR_UNDERRUN`  in  1  clears `UNDERRUN`.
- `CMD_OUT`  out  1  serial command bit, registered.
- `FRAME_START`  out  1  high during the first bit of every transmitted frame.
- `UNDERRUN`  out  1  sticky flag: FIFO ran empty mid-command.

## Operation
- Constants: `SYNC_WORD` = 16'h817E, `NOOP_WORD` = 16'h6969.
- 4-bit bit counter runs 0..15. At each frame boundary (counter = 15, or first cycle after reset) one frame is selected into a 16-bit shift register, and `CMD_OUT` then shifts MSB-first.
- Frame-selection states: SEND_SYNC, SEND_DATA, SEND_NOOP. Priority at each boundary:
  1. First frame after reset → SYNC.
  2. Not mid-command and `sync_cnt` ≥ `SYNC_INTERVAL` → SYNC; `sync_cnt` := 0.
  3. FIFO non-empty → pop → DATA. `mid_cmd` := !FRAME_LAST of the popped entry.
  4. FIFO empty → NOOP. If `mid_cmd` is set, set `UNDERRUN`; `mid_cmd` is unchanged.
- Every non-sync frame increments `sync_cnt`, saturating at `SYNC_INTERVAL`.
- Sync is never inserted inside a multi-frame command. This can delay it past `SYNC_INTERVAL`; `sync_cnt` saturates and the sync goes out at the next command boundary.
- FIFO entries are 17 bits: {LAST, DATA}.
- `CLR_UNDERRUN` set and underrun event in the same cycle: set wins.

## Timing
- Reset values: `CMD_OUT`=0, `FRAME_START`=0, `UNDERRUN`=0, `FRAME_READY`=0 while reset is asserted.
  - `FRAME_READY`=1 from the first clock after release.
  - FIFO empty, `sync_cnt`=0, `mid_cmd`=0, bit counter=15, so a boundary occurs immediately.
- First edge after reset release: SYNC is loaded. `CMD_OUT` carries bit 15 of SYNC on the following cycle, with `FRAME_START`=1.
- Frame period is exactly 16 cycles with no gaps. `FRAME_START` is high once per 16 cycles.
- Latency: a frame accepted at cycle t, with the FIFO otherwise empty, is selected at the next boundary at or after t+1. Its first bit appears on `CMD_OUT` one cycle after that boundary.
- Pop occurs only at a boundary. A push and a pop in the same cycle are both honoured. `FRAME_READY` is derived from the registered count: it stays low on the full cycle even if a pop occurs.
- Reset asserted mid-frame: the output drops to 0 asynchronously, the FIFO is flushed, and the partial frame is lost.

## Structure
- Package `rd53_cmd_pkg`: `SYNC_WORD`, `NOOP_WORD`, `frame_t` (logic [15:0]), frame-select state enum.
- Sub-module `rd53_cmd_fifo`: synchronous FIFO with parameterised depth, the same clock and async active-low reset, and full/empty derived from a count register. The top level contains the selector FSM, counters and shift register.

## Test plan
- Reset release, no input → first frame 16'h817E; then, with `SYNC_INTERVAL`=4, the pattern SYNC, 4×NOOP (16'h6969), SYNC repeating. `FRAME_START` spacing is 16 cycles.
- Push single frame 16'h5C3A with LAST=1 into an idle link → appears in full, MSB-first, at the next boundary. `sync_cnt` increments and no `UNDERRUN`.
- Push a 3-frame command (LAST on the third) when `sync_cnt`=3, `SYNC_INTERVAL`=4 → the three frames go out back-to-back, and SYNC follows only after the third.
- Push frame 1 of a 2-frame command, then withhold frame 2 for 40 cycles → NOOPs are emitted and `UNDERRUN`=1. Asserting `CLR_UNDERRUN` after frame 2 is sent clears it.
- Burst of 10 frames with `FIFO_DEPTH`=8 and `FRAME_VALID` held → `FRAME_READY` drops once 8 are stored. All 10 are transmitted in order with none lost or duplicated.
- Assert `RESET_N` low at bit 7 of a data frame with 3 frames queued → `CMD_OUT`=0 immediately. After release the first frame is SYNC and no queued frame appears.

Source files
------------

// File: rtl/rd53_cmd_pkg.sv
// Shared types and constants for the RD53A command-stream serializer.
package rd53_cmd_pkg;

  typedef logic [15:0] frame_t;

  localparam frame_t SYNC_WORD = 16'h817E;
  localparam frame_t NOOP_WORD = 16'h6969;

  typedef enum logic [1:0] {
    SEND_SYNC,
    SEND_DATA,
    SEND_NOOP
  } sel_state_e;

  typedef struct packed {
    logic   last;
    frame_t data;
  } cmd_entry_t;

endpackage

// File: rtl/rd53_cmd_serializer_if.sv
// Valid/ready frame-input bus of the command serializer.
interface rd53_cmd_serializer_if;
  import rd53_cmd_pkg::*;

  frame_t FRAME_DATA;
  logic   FRAME_LAST;
  logic   FRAME_VALID;
  logic   FRAME_READY;

  modport master (
    output FRAME_DATA,
    output FRAME_LAST,
    output FRAME_VALID,
    input  FRAME_READY
  );

  modport slave (
    input  FRAME_DATA,
    input  FRAME_LAST,
    input  FRAME_VALID,
    output FRAME_READY
  );

endinterface

// File: rtl/rd53_cmd_fifo.sv
// Synchronous command-frame FIFO; full/empty come from a registered occupancy count.
module rd53_cmd_fifo
  import rd53_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  cmd_entry_t wdata_i,
  output logic       full_o,
  input  logic       pop_i,
  output cmd_entry_t rdata_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  cmd_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rd53_cmd_serializer.sv
// RD53A CMD line generator: buffers frames, serializes MSB-first, inserts SYNC
// periodically at command boundaries and fills idle time with NOOP.
module rd53_cmd_serializer
  import rd53_cmd_pkg::*;
#(
  parameter int unsigned SYNC_INTERVAL = 32,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                        CMD_CLK,
  input  logic                        RESET_N,
  rd53_cmd_serializer_if.slave        frm_if,
  input  logic                        CLR_UNDERRUN,
  output logic                        CMD_OUT,
  output logic                        FRAME_START,
  output logic                        UNDERRUN
);

  localparam logic [7:0] SYNC_LIMIT = 8'(SYNC_INTERVAL);

  sel_state_e state_q, state_d;
  logic [3:0] bit_cnt_q;
  logic       first_q;
  frame_t     shift_q, shift_d;
  logic       cmd_out_q, cmd_out_d;
  logic       frame_start_q;
  logic [7:0] sync_cnt_q, sync_cnt_d;
  logic       mid_q, mid_d;
  logic       underrun_q, underrun_d;

  logic       boundary;
  logic       pop;
  logic       uflow;
  frame_t     word;
  logic       fifo_full, fifo_empty;
  cmd_entry_t fifo_rdata;

  rd53_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CMD_CLK),
    .rst_ni  (RESET_N),
    .push_i  (frm_if.FRAME_VALID && frm_if.FRAME_READY),
    .wdata_i (cmd_entry_t'{last: frm_if.FRAME_LAST, data: frm_if.FRAME_DATA}),
    .full_o  (fifo_full),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty)
  );

  assign frm_if.FRAME_READY = !first_q && !fifo_full;
  assign boundary           = (bit_cnt_q == 4'hF);

  // sync_cnt is bumped on the first bit of each non-sync frame rather than at
  // the boundary; the count is still settled long before the next boundary.
  always_comb begin
    state_d    = state_q;
    mid_d      = mid_q;
    sync_cnt_d = sync_cnt_q;
    pop        = 1'b0;
    uflow      = 1'b0;
    if (boundary) begin
      if (first_q || (!mid_q && (sync_cnt_q >= SYNC_LIMIT))) begin
        state_d    = SEND_SYNC;
        sync_cnt_d = '0;
      end else if (!fifo_empty) begin
        state_d = SEND_DATA;
        pop     = 1'b1;
        mid_d   = !fifo_rdata.last;
      end else begin
        state_d = SEND_NOOP;
        uflow   = mid_q;
      end
    end else if (frame_start_q && (state_q != SEND_SYNC) && (sync_cnt_q < SYNC_LIMIT)) begin
      sync_cnt_d = sync_cnt_q + 8'd1;
    end

    case (state_d)
      SEND_SYNC: word = SYNC_WORD;
      SEND_DATA: word = fifo_rdata.data;
      default:   word = NOOP_WORD;
    endcase

    if (boundary) begin
      shift_d   = {word[14:0], 1'b0};
      cmd_out_d = word[15];
    end else begin
      shift_d   = {shift_q[14:0], 1'b0};
      cmd_out_d = shift_q[15];
    end

    underrun_d = uflow ? 1'b1 : (CLR_UNDERRUN ? 1'b0 : underrun_q);
  end

  always_ff @(posedge CMD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= SEND_NOOP;
      bit_cnt_q     <= 4'hF;
      first_q       <= 1'b1;
      shift_q       <= '0;
      cmd_out_q     <= 1'b0;
      frame_start_q <= 1'b0;
      sync_cnt_q    <= '0;
      mid_q         <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_q + 4'd1;
      first_q       <= 1'b0;
      shift_q       <= shift_d;
      cmd_out_q     <= cmd_out_d;
      frame_start_q <= boundary;
      sync_cnt_q    <= sync_cnt_d;
      mid_q         <= mid_d;
      underrun_q    <= underrun_d;
    end
  end

  assign CMD_OUT     = cmd_out_q;
  assign FRAME_START = frame_start_q;
  assign UNDERRUN    = underrun_q;

endmodule

// File: tb/tb_rd53_cmd_serializer.sv
// Self-checking bench for rd53_cmd_serializer against a frame-level reference model.
`timescale 1ns/1ps
module tb_rd53_cmd_serializer;

  localparam int unsigned SI    = 4;
  localparam int unsigned DEPTH = 8;
  localparam logic [15:0] SYNC_W = 16'h817E;
  localparam logic [15:0] NOOP_W = 16'h6969;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic cmd_out, frame_start, underrun;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned busy_seen = 0;

  rd53_cmd_serializer_if frm_if();

  rd53_cmd_serializer #(
    .SYNC_INTERVAL (SI),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .CMD_CLK      (clk),
    .RESET_N      (rst_n),
    .frm_if       (frm_if),
    .CLR_UNDERRUN (clr),
    .CMD_OUT      (cmd_out),
    .FRAME_START  (frame_start),
    .UNDERRUN     (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: one frame chosen every 16 clocks from the queue.
  logic [16:0]  m_q[$];
  logic [16:0]  m_e;
  bit           m_first, m_mid, m_uf, m_rdy, m_have_cur, m_cur_data, m_uf_evt, m_push_ok;
  int unsigned  m_scnt, m_cyc, m_idx;
  logic [15:0]  m_cur;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_first = 1; m_mid = 0; m_uf = 0; m_rdy = 0;
      m_have_cur = 0; m_cur_data = 0;
      m_scnt = 0; m_cyc = 0; m_idx = 0; m_cur = '0;
    end else begin
      m_push_ok = frm_if.FRAME_VALID && m_rdy;
      m_uf_evt  = 0;
      m_idx     = m_cyc % 16;
      if (m_idx == 0) begin
        if (m_first || (!m_mid && m_scnt >= SI)) begin
          m_cur = SYNC_W; m_cur_data = 0; m_scnt = 0;
        end else begin
          if (m_q.size() > 0) begin
            m_e = m_q.pop_front();
            m_cur = m_e[15:0]; m_cur_data = 1; m_mid = !m_e[16];
          end else begin
            m_cur = NOOP_W; m_cur_data = 0;
            if (m_mid) m_uf_evt = 1;
          end
          if (m_scnt < SI) m_scnt++;
        end
        m_first = 0;
        m_have_cur = 1;
      end
      if (m_uf_evt) m_uf = 1;
      else if (clr) m_uf = 0;
      if (m_push_ok) m_q.push_back({frm_if.FRAME_LAST, frm_if.FRAME_DATA});
      m_rdy = (m_q.size() < DEPTH);
      m_cyc++;
    end
  end

  logic [15:0] obs_word = '0;
  logic [15:0] obs_fs = '0;
  int unsigned nframe = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      nframe = 0;
    end else begin
      check("ready", frm_if.FRAME_READY, m_rdy);
      check("underrun", underrun, m_uf);
      obs_word = {obs_word[14:0], cmd_out};
      obs_fs   = {obs_fs[14:0], frame_start};
      if (m_have_cur && m_idx == 15) begin
        check("frame", obs_word, m_cur);
        check("frame_start", obs_fs, 16'h8000);
        if (nframe == 0) check("first_sync", obs_word, SYNC_W);
        if (nframe == 1) check("first_noop", obs_word, NOOP_W);
        nframe++;
      end
    end
  end

  task automatic push(input logic [15:0] d, input logic l);
    bit acc;
    acc = 0;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      frm_if.FRAME_DATA  = d;
      frm_if.FRAME_LAST  = l;
      frm_if.FRAME_VALID = 1'b1;
      acc = frm_if.FRAME_READY;
      if (!acc) busy_seen++;
    end
    check("push_accept", acc, 1);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      frm_if.FRAME_VALID = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    frm_if.FRAME_VALID = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_cmd_out", cmd_out, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_underrun", underrun, 0);
    check("rst_ready", frm_if.FRAME_READY, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    rst_n = 1'b1;
    clr = 1'b0;
    frm_if.FRAME_DATA  = '0;
    frm_if.FRAME_LAST  = 1'b0;
    frm_if.FRAME_VALID = 1'b0;
    @(negedge clk);
    do_reset();

    // idle link: SYNC then NOOPs with periodic SYNC
    idle(16 * 12);

    push(16'h5C3A, 1'b1);
    idle(48);
    check("single_no_underrun", underrun, 0);

    // three-frame command started when sync_cnt is one short of the limit
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      frm_if.FRAME_VALID = 1'b0;
      hit = (m_scnt == 3) && !m_mid;
    end
    check("scnt3_window", hit, 1);
    push(16'hA001, 1'b0);
    push(16'hA002, 1'b0);
    push(16'hA003, 1'b1);
    idle(96);

    // underrun on a withheld second frame, then clear
    push(16'hB001, 1'b0);
    idle(80);
    check("underrun_set", underrun, 1);
    push(16'hB002, 1'b1);
    idle(48);
    pulse_clr();
    check("underrun_clr", underrun, 0);

    // burst of ten with VALID held
    busy_seen = 0;
    for (int i = 0; i < 10; i++) push(16'($urandom), (i == 9));
    check("burst_ready_drop", (busy_seen > 0), 1);
    idle(16 * 12);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      push(16'($urandom), ($urandom_range(0, 2) != 0));
      idle($urandom_range(0, 20));
      if ($urandom_range(0, 4) == 0) pulse_clr();
    end
    push(16'h7E57, 1'b1);
    idle(16 * 14);

    // reset in the middle of a data frame with three frames queued
    for (int i = 0; i < 4; i++) push(16'hC000 + 16'(i), 1'b1);
    idle(1);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = m_cur_data && (m_idx == 8) && (m_q.size() == 3);
    end
    check("midframe_window", hit, 1);
    #2;
    do_reset();
    idle(16 * 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
